// File: rtl/pov_load_sched_pkg.sv
// Shared definitions for the POV frame-load scheduler: FSM encodings and axis indices.
package pov_load_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_RUN  = 2'd0,
    SCHED_PEND = 2'd1,
    SCHED_LOAD = 2'd2
  } sched_state_e;

  localparam int NUM_AXES = 2;
  localparam int AX_PX    = 0;
  localparam int AX_PY    = 1;

  function automatic logic sched_is_busy(input sched_state_e s);
    return s != SCHED_RUN;
  endfunction

endpackage

// File: rtl/pov_load_sched_inc_req_latch.sv
// Sticky per-axis increment request: set by the button, cleared when consumed by a load.
module inc_req_latch (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic consume,
  output logic fire
);

  logic req;

  // A button held during the consuming cycle re-arms the request.
  always_ff @(posedge clk) begin
    if (reset) req <= 1'b0;
    else       req <= (req & ~consume) | set;
  end

  assign fire = req & consume;

endmodule

// File: rtl/pov_load_sched.sv
// Frame-level load scheduler for the POV vector registers.
// Optional forced-load watchdog enabled by defining POV_SCHED_WATCHDOG_EN.
module pov_load_sched
  import pov_load_sched_pkg::*;
#(
  parameter int INC_DIV     = 2,
  parameter int DIV_W       = 4,
  parameter int FRAME_W     = 8,
  parameter int WDOG_CYCLES = 1024,
  parameter int WDOG_W      = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_frame_end,
  input  logic               i_trace_busy,
  input  logic               i_btn_px,
  input  logic               i_btn_py,
  output logic               o_load_if_ready,
  output logic               o_inc_px,
  output logic               o_inc_py,
  output logic               o_sched_busy,
  output logic [FRAME_W-1:0] o_frame_count,
  output logic               o_overrun
);

  sched_state_e          state, state_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  div_hit;
  logic                  load_now;
  logic                  consume;
  logic                  wdog_force;
  logic [NUM_AXES-1:0]   btn;
  logic [NUM_AXES-1:0]   inc;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= SCHED_RUN;
    else       state <= state_nxt;
  end

  // FSM: next state; the unused encoding falls back to RUN
  always_comb begin
    state_nxt = SCHED_RUN;
    case (state)
      SCHED_RUN:  state_nxt = i_frame_end ? SCHED_PEND : SCHED_RUN;
      SCHED_PEND: state_nxt = (!i_trace_busy || wdog_force) ? SCHED_LOAD : SCHED_PEND;
      SCHED_LOAD: state_nxt = SCHED_RUN;
      default:    state_nxt = SCHED_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load_now     = (state == SCHED_LOAD);
    o_sched_busy = sched_is_busy(state);
  end

  assign o_load_if_ready = load_now;

  // Increment divider: requests are only honoured on every INC_DIV-th load.
  assign div_hit = (div_cnt == '0);
  assign consume = load_now & div_hit;

  always_ff @(posedge clk) begin
    if (reset)
      div_cnt <= '0;
    else if (load_now)
      div_cnt <= (div_cnt == DIV_W'(INC_DIV - 1)) ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)         o_frame_count <= '0;
    else if (load_now) o_frame_count <= o_frame_count + 1'b1;
  end

  // Overrun: a frame end arriving while a load is still outstanding, or a forced load.
  always_ff @(posedge clk) begin
    if (reset) o_overrun <= 1'b0;
    else       o_overrun <= o_overrun | (i_frame_end & (state != SCHED_RUN)) | wdog_force;
  end

`ifdef POV_SCHED_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog;

  always_ff @(posedge clk) begin
    if (reset)                    wdog <= '0;
    else if (state == SCHED_PEND) wdog <= wdog + 1'b1;
    else                          wdog <= '0;
  end

  assign wdog_force = (state == SCHED_PEND) & i_trace_busy & (wdog == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^{WDOG_CYCLES[0], WDOG_W[0]};
  assign wdog_force      = 1'b0;
`endif

  assign btn[AX_PX] = i_btn_px;
  assign btn[AX_PY] = i_btn_py;

  inc_req_latch u_req [NUM_AXES-1:0] (
    .clk     (clk),
    .reset   (reset),
    .set     (btn),
    .consume ({NUM_AXES{consume}}),
    .fire    (inc)
  );

  assign o_inc_px = inc[AX_PX];
  assign o_inc_py = inc[AX_PY];

endmodule

// File: tb/tb_pov_load_sched.sv
// Directed bench for pov_load_sched: per-cycle vector table plus multi-cycle corner sequences.
module tb_pov_load_sched;

  logic       clk, reset;
  logic       fe, busy, bpx, bpy;
  logic       o_load, o_ipx, o_ipy, o_sbusy, o_ovr;
  logic [7:0] o_fc;

  int n_chk  = 0;
  int n_fail = 0;

  pov_load_sched #(
    .INC_DIV(2), .DIV_W(4), .FRAME_W(8), .WDOG_CYCLES(16), .WDOG_W(5)
  ) dut (
    .clk(clk), .reset(reset),
    .i_frame_end(fe), .i_trace_busy(busy), .i_btn_px(bpx), .i_btn_py(bpy),
    .o_load_if_ready(o_load), .o_inc_px(o_ipx), .o_inc_py(o_ipy),
    .o_sched_busy(o_sbusy), .o_frame_count(o_fc), .o_overrun(o_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fe, busy, bpx, bpy;
    logic       load, ipx, ipy, sbusy, ovr;
    logic [7:0] fc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fe = 0; busy = 0; bpx = 0; bpy = 0;
    nxt(); nxt();
    reset = 1'b0;
  endtask

  // frame_end with busy low, then check the strobe cycle two cycles later
  task automatic run_frame(input string nm, input logic exp_px, input logic exp_py);
    fe = 1'b1; busy = 1'b0;
    nxt();
    fe = 1'b0;
    nxt();
    @(negedge clk);
    chk({nm, "_load"}, 32'(o_load), 32'(1'b1));
    chk({nm, "_px"},   32'(o_ipx),  32'(exp_px));
    chk({nm, "_py"},   32'(o_ipy),  32'(exp_py));
    nxt();
  endtask

  vec_t vecs [21];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_len;
    int load_at;
    // fe busy bpx bpy | load ipx ipy sbusy ovr fc
    vecs = '{
      '{0,0,0,0, 0,0,0,0,0,8'd0},
      '{1,0,0,0, 0,0,0,0,0,8'd0},
      '{0,0,0,0, 0,0,0,1,0,8'd0},
      '{0,0,0,0, 1,0,0,1,0,8'd0},
      '{0,0,0,0, 0,0,0,0,0,8'd1},
      '{0,0,1,0, 0,0,0,0,0,8'd1},
      '{1,0,0,0, 0,0,0,0,0,8'd1},
      '{0,0,0,0, 0,0,0,1,0,8'd1},
      '{0,0,0,0, 1,0,0,1,0,8'd1},
      '{0,0,0,0, 0,0,0,0,0,8'd2},
      '{1,0,0,1, 0,0,0,0,0,8'd2},
      '{0,0,0,0, 0,0,0,1,0,8'd2},
      '{0,0,0,0, 1,1,1,1,0,8'd2},
      '{0,0,0,0, 0,0,0,0,0,8'd3},
      '{1,1,0,0, 0,0,0,0,0,8'd3},
      '{1,1,0,0, 0,0,0,1,0,8'd3},
      '{0,1,0,0, 0,0,0,1,1,8'd3},
      '{0,0,0,0, 0,0,0,1,1,8'd3},
      '{1,0,0,0, 1,0,0,1,1,8'd3},
      '{0,0,0,0, 0,0,0,0,1,8'd4},
      '{0,0,0,0, 0,0,0,0,1,8'd4}
    };

    do_reset();
    for (int i = 0; i < 21; i++) begin
      fe = vecs[i].fe; busy = vecs[i].busy; bpx = vecs[i].bpx; bpy = vecs[i].bpy;
      @(negedge clk);
      chk($sformatf("vec%0d_load", i),  32'(o_load),  32'(vecs[i].load));
      chk($sformatf("vec%0d_px", i),    32'(o_ipx),   32'(vecs[i].ipx));
      chk($sformatf("vec%0d_py", i),    32'(o_ipy),   32'(vecs[i].ipy));
      chk($sformatf("vec%0d_sbusy", i), 32'(o_sbusy), 32'(vecs[i].sbusy));
      chk($sformatf("vec%0d_ovr", i),   32'(o_ovr),   32'(vecs[i].ovr));
      chk($sformatf("vec%0d_fc", i),    32'(o_fc),    32'(vecs[i].fc));
      nxt();
    end

    // Long trace: strobe must follow the busy drop by one cycle
`ifdef POV_SCHED_WATCHDOG_EN
    busy_len = 12;
`else
    busy_len = 40;
`endif
    do_reset();
    fe = 1'b1; busy = 1'b1;
    nxt();
    fe = 1'b0;
    for (int i = 0; i < busy_len; i++) begin
      @(negedge clk);
      chk($sformatf("busy_wait%0d_load", i), 32'(o_load), 32'(1'b0));
      chk($sformatf("busy_wait%0d_sbusy", i), 32'(o_sbusy), 32'(1'b1));
      nxt();
    end
    busy = 1'b0;
    @(negedge clk);
    chk("busy_drop_load", 32'(o_load), 32'(1'b0));
    nxt();
    @(negedge clk);
    chk("busy_strobe", 32'(o_load), 32'(1'b1));
    nxt();
    @(negedge clk);
    chk("busy_strobe_len", 32'(o_load), 32'(1'b0));
    chk("busy_fc", 32'(o_fc), 32'd1);
    chk("busy_ovr", 32'(o_ovr), 32'(1'b0));

    // Held button: increment on loads 1,3,5 only
    do_reset();
    bpx = 1'b1;
    run_frame("held1", 1'b1, 1'b0);
    run_frame("held2", 1'b0, 1'b0);
    run_frame("held3", 1'b1, 1'b0);
    run_frame("held4", 1'b0, 1'b0);
    run_frame("held5", 1'b1, 1'b0);
    bpx = 1'b0;

    // Single-cycle pulse: consumed once on the first load
    do_reset();
    bpx = 1'b1; nxt(); bpx = 1'b0; nxt();
    run_frame("pulse1", 1'b1, 1'b0);
    run_frame("pulse2", 1'b0, 1'b0);
    run_frame("pulse3", 1'b0, 1'b0);

    // Reset while pending with a request latched
    do_reset();
    bpx = 1'b1; nxt(); bpx = 1'b0;
    fe = 1'b1; busy = 1'b1; nxt();
    fe = 1'b0; nxt();
    @(negedge clk);
    chk("rst_pend_sbusy", 32'(o_sbusy), 32'(1'b1));
    reset = 1'b1; nxt(); reset = 1'b0; busy = 1'b0;
    @(negedge clk);
    chk("rst_after_sbusy", 32'(o_sbusy), 32'(1'b0));
    chk("rst_after_load",  32'(o_load),  32'(1'b0));
    chk("rst_after_fc",    32'(o_fc),    32'd0);
    nxt();
    run_frame("rst_next", 1'b0, 1'b0);

    // Tracer stuck busy
    do_reset();
    busy = 1'b1; fe = 1'b1;
    nxt();
    fe = 1'b0;
    load_at = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (o_load === 1'b1 && load_at < 0) load_at = k;
`ifdef POV_SCHED_WATCHDOG_EN
      if (k == 16) chk("wdog_ovr_before", 32'(o_ovr), 32'(1'b0));
      if (k == 17) chk("wdog_ovr_at_load", 32'(o_ovr), 32'(1'b1));
`endif
      nxt();
    end
`ifdef POV_SCHED_WATCHDOG_EN
    chk("wdog_load_cycle", 32'(load_at), 32'd17);
`else
    chk("stuck_no_load", 32'(load_at), 32'hFFFF_FFFF);
    @(negedge clk);
    chk("stuck_sbusy", 32'(o_sbusy), 32'(1'b1));
    chk("stuck_ovr",   32'(o_ovr),   32'(1'b0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
